// File: rtl/ivs_axi_pkg.sv
// Shared constants, widths and types for the IVS AXI read arbiter.
package ivs_axi_pkg;

    localparam int unsigned ID_W  = 4;
    localparam int unsigned IDX_W = 2;
    localparam int unsigned SEQ_W = 2;
    localparam int unsigned LEN_W = 6;
    localparam int unsigned CNT_W = 3;   // holds 0..4 outstanding bursts

    localparam logic [2:0] AXI_SIZE_16B   = 3'b100;
    localparam logic [1:0] AXI_BURST_INCR = 2'b01;
    localparam logic [1:0] RESP_OKAY      = 2'b00;

    typedef enum logic [0:0] {
        IDLE = 1'b0,
        HOLD = 1'b1
    } arb_state_t;

    // arid layout: owning requester in the upper bits, per-requester sequence below
    typedef struct packed {
        logic [IDX_W-1:0] idx;
        logic [SEQ_W-1:0] seq;
    } arid_t;

endpackage

// File: rtl/ivs_axi_rd_arb_if.sv
// AXI read channel (AR + R) bundle.
//   master: drives AR fields and rready (the arbiter)
//   slave : drives arready and the R beat fields (memory side)
interface ivs_axi_rd_arb_if import ivs_axi_pkg::*; #(
    parameter int unsigned AW   = 32,
    parameter int unsigned BDWD = 128
);

    logic              arvalid;
    logic              arready;
    logic [ID_W-1:0]   arid;
    logic [AW-1:0]     araddr;
    logic [LEN_W-1:0]  arlen;
    logic [2:0]        arsize;
    logic [1:0]        arburst;

    logic              rvalid;
    logic              rready;
    logic [ID_W-1:0]   rid;
    logic [BDWD-1:0]   rdata;
    logic              rlast;
    logic [1:0]        rresp;

    modport master (
        output arvalid, arid, araddr, arlen, arsize, arburst, rready,
        input  arready, rvalid, rid, rdata, rlast, rresp
    );

    modport slave (
        input  arvalid, arid, araddr, arlen, arsize, arburst, rready,
        output arready, rvalid, rid, rdata, rlast, rresp
    );

endinterface

// File: rtl/ivs_rr_pick.sv
// Round-robin picker: first set bit of req at or after ptr, wrapping.
//   req   : request vector
//   ptr   : starting index
//   any_c : at least one request set
//   idx_c : chosen index (0 when none)
module ivs_rr_pick #(
    parameter  int unsigned N  = 4,
    localparam int unsigned PW = $clog2(N)
) (
    input  logic [N-1:0]  req,
    input  logic [PW-1:0] ptr,
    output logic          any_c,
    output logic [PW-1:0] idx_c
);

    logic [PW-1:0] cand;

    always_comb begin
        any_c = 1'b0;
        idx_c = '0;
        cand  = '0;
        for (int unsigned k = 0; k < N; k++) begin
            cand = PW'((32'(ptr) + k) % N);
            if (!any_c && req[cand]) begin
                any_c = 1'b1;
                idx_c = cand;
            end
        end
    end

endmodule

// File: rtl/ivs_axi_rd_arb.sv
// Round-robin arbiter sharing one AXI read channel among NUM_REQ engines.
//   aclk/arst      : clock, async active-high reset
//   req_ar*        : per-requester burst requests (packed, requester 0 in LSBs)
//   req_r*         : R beats steered back to the owner selected by rid[3:2]
//   err_sts/err_clr: sticky per-requester error flags and their clear pulses
//   bus            : AXI AR/R channel toward IVS_TOP
module ivs_axi_rd_arb import ivs_axi_pkg::*; #(
    parameter int unsigned NUM_REQ  = 4,
    parameter int unsigned AW       = 32,
    parameter int unsigned BDWD     = 128,
    parameter int unsigned MAX_OUTS = 4
) (
    input  logic                     aclk,
    input  logic                     arst,
    input  logic [NUM_REQ-1:0]       req_arvalid,
    output logic [NUM_REQ-1:0]       req_arready,
    input  logic [NUM_REQ*AW-1:0]    req_araddr,
    input  logic [NUM_REQ*LEN_W-1:0] req_arlen,
    output logic [NUM_REQ-1:0]       req_rvalid,
    output logic [BDWD-1:0]          req_rdata,
    output logic                     req_rlast,
    input  logic [NUM_REQ-1:0]       req_rready,
    output logic [NUM_REQ-1:0]       err_sts,
    input  logic [NUM_REQ-1:0]       err_clr,
    ivs_axi_rd_arb_if.master         bus
);

    localparam logic [0:0] ST_IDLE = 1'(IDLE);
    localparam logic [0:0] ST_HOLD = 1'(HOLD);

    logic [0:0]         state_q, state_d;
    logic [IDX_W-1:0]   rr_ptr_q, rr_ptr_d;
    logic [IDX_W-1:0]   grant_q, grant_d;
    logic               arvalid_q, arvalid_d;
    arid_t              arid_q, arid_d;
    logic [AW-1:0]      araddr_q, araddr_d;
    logic [LEN_W-1:0]   arlen_q, arlen_d;
    logic [NUM_REQ-1:0] req_arready_q, req_arready_d;
    logic [CNT_W-1:0]   outs_cnt_q [NUM_REQ];
    logic [CNT_W-1:0]   outs_cnt_d [NUM_REQ];
    logic [SEQ_W-1:0]   seq_q [NUM_REQ];
    logic [SEQ_W-1:0]   seq_d [NUM_REQ];
    logic [NUM_REQ-1:0] err_q, err_d;

    logic [NUM_REQ-1:0] eligible_c;
    logic               pick_any_c;
    logic [IDX_W-1:0]   pick_idx_c;
    logic [IDX_W-1:0]   owner_c;
    logic               owner_idle_c;
    logic               ar_hs_c;
    logic               beat_acc_c;
    logic [NUM_REQ-1:0] cnt_inc_c, cnt_dec_c, err_set_c;

    // Eligibility; a requester whose accept pulse is out this cycle still shows
    // its old request and must not be granted twice.
    always_comb begin
        for (int i = 0; i < NUM_REQ; i++) begin
            eligible_c[i] = req_arvalid[i] && !req_arready_q[i]
                            && (32'(outs_cnt_q[i]) < MAX_OUTS);
        end
    end

    ivs_rr_pick #(.N(NUM_REQ)) u_pick (
        .req   (eligible_c),
        .ptr   (rr_ptr_q),
        .any_c (pick_any_c),
        .idx_c (pick_idx_c)
    );

    // R steering; beats for an owner with nothing outstanding are swallowed.
    assign owner_c      = bus.rid[ID_W-1 -: IDX_W];
    assign owner_idle_c = (outs_cnt_q[owner_c] == '0);
    assign bus.rready   = owner_idle_c ? bus.rvalid : req_rready[owner_c];
    assign beat_acc_c   = bus.rvalid && bus.rready;
    assign req_rdata    = bus.rdata;
    assign req_rlast    = bus.rlast;

    always_comb begin
        req_rvalid = '0;
        if (bus.rvalid && !owner_idle_c) begin
            req_rvalid[owner_c] = 1'b1;
        end
    end

    assign ar_hs_c = arvalid_q && bus.arready;

    // Per-requester counter and error events
    always_comb begin
        for (int i = 0; i < NUM_REQ; i++) begin
            cnt_inc_c[i] = ar_hs_c && (grant_q == IDX_W'(i));
            cnt_dec_c[i] = beat_acc_c && bus.rlast && !owner_idle_c
                           && (owner_c == IDX_W'(i));
            err_set_c[i] = beat_acc_c && (owner_c == IDX_W'(i))
                           && ((bus.rresp != RESP_OKAY) || owner_idle_c);
        end
    end

    // Next-state and registered-output logic
    always_comb begin
        state_d       = state_q;
        rr_ptr_d      = rr_ptr_q;
        grant_d       = grant_q;
        arvalid_d     = arvalid_q;
        arid_d        = arid_q;
        araddr_d      = araddr_q;
        arlen_d       = arlen_q;
        req_arready_d = '0;
        outs_cnt_d    = outs_cnt_q;
        seq_d         = seq_q;
        err_d         = err_q;

        case (state_q)
            ST_IDLE: begin
                if (pick_any_c) begin
                    state_d   = ST_HOLD;
                    grant_d   = pick_idx_c;
                    arvalid_d = 1'b1;
                    arid_d    = arid_t'{idx: pick_idx_c, seq: seq_q[pick_idx_c]};
                    araddr_d  = req_araddr[pick_idx_c*AW +: AW];
                    arlen_d   = req_arlen[pick_idx_c*LEN_W +: LEN_W];
                end
            end
            ST_HOLD: begin
                if (ar_hs_c) begin
                    state_d                = ST_IDLE;
                    arvalid_d              = 1'b0;
                    req_arready_d[grant_q] = 1'b1;
                    seq_d[grant_q]         = seq_q[grant_q] + 1'b1;
                    rr_ptr_d               = grant_q + 1'b1;
                end
            end
            default: state_d = ST_IDLE;
        endcase

        for (int i = 0; i < NUM_REQ; i++) begin
            if (cnt_inc_c[i] && !cnt_dec_c[i]) begin
                outs_cnt_d[i] = outs_cnt_q[i] + 1'b1;
            end else if (cnt_dec_c[i] && !cnt_inc_c[i]) begin
                outs_cnt_d[i] = outs_cnt_q[i] - 1'b1;
            end
            if (err_set_c[i]) begin
                err_d[i] = 1'b1;
            end else if (err_clr[i]) begin
                err_d[i] = 1'b0;
            end
        end
    end

    // State register
    always_ff @(posedge aclk or posedge arst) begin
        if (arst) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Datapath and tracking registers
    always_ff @(posedge aclk or posedge arst) begin
        if (arst) begin
            rr_ptr_q      <= '0;
            grant_q       <= '0;
            arvalid_q     <= 1'b0;
            arid_q        <= '0;
            araddr_q      <= '0;
            arlen_q       <= '0;
            req_arready_q <= '0;
            err_q         <= '0;
            for (int i = 0; i < NUM_REQ; i++) begin
                outs_cnt_q[i] <= '0;
                seq_q[i]      <= '0;
            end
        end else begin
            rr_ptr_q      <= rr_ptr_d;
            grant_q       <= grant_d;
            arvalid_q     <= arvalid_d;
            arid_q        <= arid_d;
            araddr_q      <= araddr_d;
            arlen_q       <= arlen_d;
            req_arready_q <= req_arready_d;
            err_q         <= err_d;
            for (int i = 0; i < NUM_REQ; i++) begin
                outs_cnt_q[i] <= outs_cnt_d[i];
                seq_q[i]      <= seq_d[i];
            end
        end
    end

    assign bus.arvalid = arvalid_q;
    assign bus.arid    = arid_q;
    assign bus.araddr  = araddr_q;
    assign bus.arlen   = arlen_q;
    assign bus.arsize  = AXI_SIZE_16B;
    assign bus.arburst = AXI_BURST_INCR;
    assign req_arready = req_arready_q;
    assign err_sts     = err_q;

endmodule
